// File: rtl/mainbus_pkg.sv
// mainbus_pkg: shared widths, types and word constants for the main transfer bus
package mainbus_pkg;
  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0]   byte_t;
  typedef logic [2*BYTE_W-1:0] word_t;
  localparam word_t WORD_ZERO = 16'h0000;
  localparam word_t WORD_ONES = 16'hFFFF;
endpackage

// File: rtl/r16b_up_dn_ld_gpr8_lane.sv
// gpr8_lane: byte-wide register lane with sync active-low clear and load enable
module gpr8_lane
  import mainbus_pkg::*;
#(
  parameter int W = BYTE_W
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;
  // clear wins; otherwise capture the parent-computed next value when enabled
  always_ff @(posedge clk) begin
    if (!clear_n) q_q <= '0;
    else if (load_en) q_q <= d;
  end
  assign q = q_q;
endmodule

// File: rtl/r16b_up_dn_ld.sv
// r16b_up_dn_ld: loadable up/down word register built from two byte lanes; R16B_UP_DN_LD_ZERO_FLAG_EN adds a registered zero output
module r16b_up_dn_ld
  import mainbus_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             reg_load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] XferBusIn,
`ifdef R16B_UP_DN_LD_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] RegOut
);
  localparam int H = WIDTH / 2;
  localparam logic [H-1:0] ONE = 1;
  logic load, up, dn, en, cy, bw, hi_en;
  logic [H-1:0] lo_q, hi_q, lo_d, hi_d;
  assign load  = ~reg_load;
  assign up    = inc & ~dec;
  assign dn    = dec & ~inc;
  assign en    = load | up | dn;
  assign hi_en = load | cy | bw;
  // next value per lane: load beats count; low lane carry/borrow steps the high lane
  always_comb begin
    cy   = up & (&lo_q);
    bw   = dn & ~(|lo_q);
    lo_d = load ? XferBusIn[H-1:0] : up ? lo_q + ONE : lo_q - ONE;
    hi_d = load ? XferBusIn[WIDTH-1:H] : cy ? hi_q + ONE : bw ? hi_q - ONE : hi_q;
  end
  gpr8_lane #(.W(H)) u_lo (
    .clk(clk), .clear_n(clear_n), .load_en(en), .d(lo_d), .q(lo_q)
  );
  gpr8_lane #(.W(H)) u_hi (
    .clk(clk), .clear_n(clear_n), .load_en(hi_en), .d(hi_d), .q(hi_q)
  );
  assign RegOut = {hi_q, lo_q};
`ifdef R16B_UP_DN_LD_ZERO_FLAG_EN
  logic zero_q;
  // flag tracks the post-edge value so it never lags RegOut
  always_ff @(posedge clk) begin
    if (!clear_n) zero_q <= 1'b1;
    else if (en) zero_q <= ({hi_d, lo_d} == '0);
  end
  assign zero = zero_q;
`endif
endmodule

// File: tb/tb_r16b_up_dn_ld.sv
// tb_r16b_up_dn_ld: scoreboard bench for the loadable up/down register
module tb_r16b_up_dn_ld;
  import mainbus_pkg::*;
  logic clk = 1'b0;
  logic clear_n = 1'b1, reg_load = 1'b1, inc = 1'b0, dec = 1'b0;
  word_t xfer = '0, reg_out, m;
`ifdef R16B_UP_DN_LD_ZERO_FLAG_EN
  logic zero;
`endif
  word_t sb[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  r16b_up_dn_ld #(.WIDTH(16)) dut (
    .clk(clk), .clear_n(clear_n), .reg_load(reg_load), .inc(inc), .dec(dec),
    .XferBusIn(xfer),
`ifdef R16B_UP_DN_LD_ZERO_FLAG_EN
    .zero(zero),
`endif
    .RegOut(reg_out)
  );
  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic cn, input logic ld, input logic i,
                     input logic d, input word_t bus, input word_t exp);
    word_t e;
    @(negedge clk);
    clear_n = cn; reg_load = ld; inc = i; dec = d; xfer = bus;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s got=empty exp=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, reg_out, e);
`ifdef R16B_UP_DN_LD_ZERO_FLAG_EN
      chk({tag, "_z"}, {15'd0, zero}, {15'd0, e == WORD_ZERO});
`endif
    end
  endtask
  initial begin
    cyc("clr_beats_ld", 0, 0, 0, 0, 16'h1234, WORD_ZERO);
    cyc("load",         1, 0, 0, 0, 16'h7B7B, 16'h7B7B);
    cyc("hold",         1, 1, 0, 0, 16'h0101, 16'h7B7B);
    cyc("inc1",         1, 1, 1, 0, 16'h0101, 16'h7B7C);
    cyc("inc2",         1, 1, 1, 0, 16'h0101, 16'h7B7D);
    cyc("inc3",         1, 1, 1, 0, 16'h0101, 16'h7B7E);
    cyc("dec1",         1, 1, 0, 1, 16'h0101, 16'h7B7D);
    cyc("dec2",         1, 1, 0, 1, 16'h0101, 16'h7B7C);
    cyc("dec3",         1, 1, 0, 1, 16'h0101, 16'h7B7B);
    cyc("ld_ffff",      1, 0, 0, 0, WORD_ONES, WORD_ONES);
    cyc("wrap_up",      1, 1, 1, 0, 16'h0000, WORD_ZERO);
    cyc("wrap_dn",      1, 1, 0, 1, 16'h0000, WORD_ONES);
    cyc("ld_00ff",      1, 0, 0, 0, 16'h00FF, 16'h00FF);
    cyc("carry",        1, 1, 1, 0, 16'h0000, 16'h0100);
    cyc("borrow",       1, 1, 0, 1, 16'h0000, 16'h00FF);
    cyc("ld_0010",      1, 0, 0, 0, 16'h0010, 16'h0010);
    cyc("inc_dec_hold", 1, 1, 1, 1, 16'h0000, 16'h0010);
    cyc("ld_beats_inc", 1, 0, 1, 0, 16'h0500, 16'h0500);
    cyc("ld_0020",      1, 0, 0, 0, 16'h0020, 16'h0020);
    cyc("mid_inc1",     1, 1, 1, 0, 16'h0000, 16'h0021);
    cyc("mid_inc2",     1, 1, 1, 0, 16'h0000, 16'h0022);
    cyc("mid_clr",      0, 1, 1, 0, 16'h0000, WORD_ZERO);
    cyc("post_clr",     1, 1, 1, 0, 16'h0000, 16'h0001);
    m = 16'h0001;
    for (int k = 0; k < 300; k++) begin
      logic cn, ld, i, d;
      word_t bus;
      cn  = ($urandom % 16) != 0;
      ld  = ($urandom % 4) != 0;
      i   = $urandom % 2;
      d   = $urandom % 2;
      bus = ($urandom % 3 == 0) ? (($urandom % 2) ? WORD_ONES : 16'h00FF) : word_t'($urandom);
      m   = !cn ? WORD_ZERO : !ld ? bus : (i && !d) ? m + 16'd1 : (d && !i) ? m - 16'd1 : m;
      cyc("rand", cn, ld, i, d, bus, m);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
